// File: rtl/spi_pkg.sv
// Shared SPI mode decode and peripheral state encoding.
package spi_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_t;

  localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

  function automatic logic spi_cpol(input int mode);
    spi_cpol = (mode & 2) != 0;
  endfunction

  function automatic logic spi_cpha(input int mode);
    spi_cpha = (mode & 1) != 0;
  endfunction
endpackage

// File: rtl/spi_in_sync.sv
// Input synchroniser for one asynchronous SPI pin, with rise/fall pulses taken
// from the last sync stage against one extra delayed copy.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);
  logic [SYNC_STAGES:0] sync_pipe;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) sync_pipe <= {(SYNC_STAGES+1){RST_VAL}};
    else          sync_pipe <= {sync_pipe[SYNC_STAGES-1:0], i_Async};
  end

  assign o_Sync = sync_pipe[SYNC_STAGES-1];
  assign o_Rise =  sync_pipe[SYNC_STAGES-1] & ~sync_pipe[SYNC_STAGES];
  assign o_Fall = ~sync_pipe[SYNC_STAGES-1] &  sync_pipe[SYNC_STAGES];
endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral: oversampled SCLK/CS_n/MOSI, byte-wide RX/TX handshakes and a
// one-deep TX holding register feeding the MISO shift register.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);
  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  spi_state_t state, state_nxt;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  logic active, enter, lead, trail, sample, drive, byte_done, load;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, hold_byte, load_byte;
  logic       hold_full, miso_q;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_Clk),
    .o_Sync(sclk_lvl_unused), .o_Rise(sclk_rise), .o_Fall(sclk_fall));
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_CS_n),
    .o_Sync(cs_lvl_unused), .o_Rise(cs_rise), .o_Fall(cs_fall));
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Async(i_SPI_MOSI),
    .o_Sync(mosi), .o_Rise(mosi_rise_unused), .o_Fall(mosi_fall_unused));

  assign active    = (state == ACTIVE);
  assign enter     = (state == IDLE) && cs_fall;
  assign lead      = CPOL ? sclk_fall : sclk_rise;
  assign trail     = CPOL ? sclk_rise : sclk_fall;
  assign sample    = active && (CPHA ? trail : lead);
  // CPHA=0 must present the MSb before the first leading edge, so entry drives too
  assign drive     = (active && (CPHA ? lead : trail)) || (!CPHA && enter);
  assign byte_done = sample && (bit_cnt == 3'd0);
  assign load      = enter || byte_done;
  assign load_byte = hold_full ? hold_byte : (i_TX_DV ? i_TX_Byte : UNDERRUN_BYTE);
  assign o_TX_Ready = ~hold_full;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_SPI_MISO_En = active;
    o_SPI_MISO    = active ? miso_q : 1'b1;
  end

  // A CS_n rise mid-byte simply rewinds the counter; the partial byte never posts
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      bit_cnt   <= 3'd7;
      rx_shift  <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (!active || cs_rise) begin
        bit_cnt <= 3'd7;
      end else if (sample) begin
        bit_cnt  <= bit_cnt - 3'd1;
        rx_shift <= {rx_shift[5:0], mosi};
        if (byte_done) begin
          o_RX_Byte <= {rx_shift, mosi};
          o_RX_DV   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
      tx_shift  <= UNDERRUN_BYTE;
      miso_q    <= 1'b1;
    end else begin
      if (load)                         hold_full <= 1'b0;
      else if (i_TX_DV && !hold_full) begin
        hold_full <= 1'b1;
        hold_byte <= i_TX_Byte;
      end
      if (load && drive) begin
        miso_q   <= load_byte[7];
        tx_shift <= {load_byte[6:0], 1'b1};
      end else if (load) begin
        tx_shift <= load_byte;
      end else if (drive) begin
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b1};
      end else if (!active) begin
        miso_q   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_peripheral.sv
// Bench: one peripheral per SPI mode, driven by a behavioural SPI master.
module tb_spi_peripheral;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] sclk, cs_n, mosi, tx_dv, rdy, rx_dv, miso, en;
  logic [3:0][7:0] tx_byte, rx_byte;

  int n_vec = 0, n_err = 0, cyc = 0;
  logic running = 1'b0, quiet = 1'b0;
  logic [3:0] exp_en, chk_en, prev_dv, prev_en, prev_miso;
  int last_drv [4];
  int dv_cnt [4];
  logic [9:0] exp_q [$];
  logic [9:0] exp_e;
  logic [2:0][7:0] mi;
  int dv0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_peripheral #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_TX_Byte(tx_byte[g]), .i_TX_DV(tx_dv[g]), .o_TX_Ready(rdy[g]),
      .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]),
      .i_SPI_Clk(sclk[g]), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi[g]),
      .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(en[g]));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_tx(input logic [1:0] m, input logic [7:0] b);
    @(negedge clk);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge clk);
    tx_dv[m]   = 1'b0;
  endtask

  // SPI master: SCLK = i_Clk/8, MSb first, mo[0] sent first, mi[k] = bytes read
  task automatic frame(input logic [1:0] m, input int nb, input logic [2:0][7:0] mo,
                       input int last_bits, output logic [2:0][7:0] mo_rd);
    logic cpol, cpha;
    int nbits;
    cpol  = m[1];
    cpha  = m[0];
    mo_rd = '1;
    @(negedge clk);
    chk_en[m]   = 1'b0;
    cs_n[m]     = 1'b0;
    last_drv[m] = cyc;
    mosi[m]     = mo[0][7];
    half();
    exp_en[m] = 1'b1;
    chk_en[m] = 1'b1;
    for (int k = 0; k < nb; k++) begin
      nbits = (k == nb - 1) ? last_bits : 8;
      for (int b = 7; b > 7 - nbits; b--) begin
        if (cpha) begin
          sclk[m] = ~cpol; mosi[m] = mo[k][b]; last_drv[m] = cyc;
          half();
          mo_rd[k][b] = miso[m];
          sclk[m] = cpol;
          if (b == 0) exp_q.push_back({m, mo[k]});
          half();
        end else begin
          mo_rd[k][b] = miso[m];
          sclk[m] = ~cpol;
          if (b == 0) exp_q.push_back({m, mo[k]});
          half();
          sclk[m] = cpol; last_drv[m] = cyc;
          if (b > 0) mosi[m] = mo[k][b-1];
          else if (k + 1 < nb) mosi[m] = mo[k+1][7];
          half();
        end
      end
    end
    chk_en[m] = 1'b0;
    cs_n[m]   = 1'b1;
    half();
    exp_en[m] = 1'b0;
    chk_en[m] = 1'b1;
    half();
  endtask

  // Per-cycle compare against the master-side model
  always @(negedge clk) begin
    if (running) begin
      for (int m = 0; m < 4; m++) begin
        if (rx_dv[m]) begin
          dv_cnt[m]++;
          chk("rx_dv_width", 32'(prev_dv[m]), 32'd0);
          if (exp_q.size() == 0) chk("rx_dv_unexpected", 32'(exp_q.size()), 32'd1);
          else begin
            exp_e = exp_q.pop_front();
            chk("rx_mode", 32'(m), 32'(exp_e[9:8]));
            chk("rx_byte", 32'(rx_byte[m]), 32'(exp_e[7:0]));
          end
        end
        if (!quiet) begin
          if (chk_en[m]) chk("miso_en", 32'(en[m]), 32'(exp_en[m]));
          if (!en[m]) chk("miso_idle", 32'(miso[m]), 32'd1);
          else if (prev_en[m] && (miso[m] !== prev_miso[m]))
            chk("miso_drive_edge", 32'((cyc - last_drv[m]) <= 4), 32'd1);
        end
        prev_dv[m]   = rx_dv[m];
        prev_en[m]   = en[m];
        prev_miso[m] = miso[m];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sclk = 4'b1100; cs_n = 4'hF; mosi = '0; tx_dv = '0; tx_byte = '0;
    exp_en = '0; chk_en = '1; prev_dv = '0; prev_en = '0; prev_miso = '1;
    for (int m = 0; m < 4; m++) begin last_drv[m] = 0; dv_cnt[m] = 0; end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk("rst_ready", 32'(rdy[m]), 32'd1);
      chk("rst_rx_dv", 32'(rx_dv[m]), 32'd0);
      chk("rst_rx_byte", 32'(rx_byte[m]), 32'd0);
      chk("rst_miso", 32'(miso[m]), 32'd1);
      chk("rst_miso_en", 32'(en[m]), 32'd0);
    end
    rst_n = 1'b1;
    running = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte exchange in every mode
    for (int m = 0; m < 4; m++) begin
      pulse_tx(2'(m), 8'h3C);
      chk("tx_ready_held", 32'(rdy[m]), 32'd0);
      frame(2'(m), 1, {8'h00, 8'h00, 8'hA5}, 8, mi);
      chk("mode_master_rd", 32'(mi[0]), 32'h3C);
      chk("mode_rx_byte", 32'(rx_byte[m]), 32'hA5);
      chk("mode_ready_after", 32'(rdy[m]), 32'd1);
      chk("mode_dv_count", 32'(dv_cnt[m]), 32'd1);
    end

    // Three bytes under one CS_n, TX refilled for only the first two
    dv0 = dv_cnt[0];
    pulse_tx(2'd0, 8'h10);
    fork
      frame(2'd0, 3, {8'h03, 8'h02, 8'h01}, 8, mi);
      begin
        repeat (20) @(negedge clk);
        pulse_tx(2'd0, 8'h20);
      end
    join
    chk("multi_rd0", 32'(mi[0]), 32'h10);
    chk("multi_rd1", 32'(mi[1]), 32'h20);
    chk("multi_rd2_underrun", 32'(mi[2]), 32'hFF);
    chk("multi_dv_count", 32'(dv_cnt[0] - dv0), 32'd3);
    chk("multi_last_rx", 32'(rx_byte[0]), 32'h03);

    // CS_n raised after 5 bits, then a full byte
    dv0 = dv_cnt[1];
    frame(2'd1, 1, {8'h00, 8'h00, 8'h5A}, 5, mi);
    chk("partial_no_dv", 32'(dv_cnt[1] - dv0), 32'd0);
    frame(2'd1, 1, {8'h00, 8'h00, 8'hC3}, 8, mi);
    chk("after_partial_rx", 32'(rx_byte[1]), 32'hC3);
    chk("after_partial_dv", 32'(dv_cnt[1] - dv0), 32'd1);
    chk("after_partial_rd", 32'(mi[0]), 32'hFF);

    // TX_DV while not ready is dropped
    pulse_tx(2'd2, 8'h77);
    pulse_tx(2'd2, 8'h88);
    chk("drop_ready", 32'(rdy[2]), 32'd0);
    frame(2'd2, 1, {8'h00, 8'h00, 8'h96}, 8, mi);
    chk("drop_master_rd", 32'(mi[0]), 32'h77);
    chk("drop_ready_after", 32'(rdy[2]), 32'd1);

    // Reset pulsed mid-byte
    dv0 = dv_cnt[0];
    quiet = 1'b1;
    fork
      frame(2'd0, 1, {8'h00, 8'h00, 8'hE7}, 5, mi);
      begin
        repeat (10) @(negedge clk);
        pulse_tx(2'd0, 8'h99);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(rdy[0]), 32'd1);
        chk("midrst_rx_dv", 32'(rx_dv[0]), 32'd0);
        chk("midrst_rx_byte", 32'(rx_byte[0]), 32'd0);
        chk("midrst_miso", 32'(miso[0]), 32'd1);
        chk("midrst_miso_en", 32'(en[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    quiet = 1'b0;
    chk("midrst_no_dv", 32'(dv_cnt[0] - dv0), 32'd0);
    pulse_tx(2'd0, 8'h5A);
    frame(2'd0, 1, {8'h00, 8'h00, 8'h96}, 8, mi);
    chk("postrst_master_rd", 32'(mi[0]), 32'h5A);
    chk("postrst_rx_byte", 32'(rx_byte[0]), 32'h96);

    repeat (10) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
